// File: rtl/disp_pkg.sv
// Shared display constants, arbiter state type and digit extraction helper
// for the multiplexed 7-segment display arbiter.
package disp_pkg;

   localparam int DIGITS = 6;
   localparam int NIB_W  = 4;
   localparam int DISP_W = DIGITS * NIB_W;
   localparam int DP_W   = 6;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // Digit k (num_k) of a packed 24-bit display word.
   function automatic logic [NIB_W-1:0] digit(input logic [DISP_W-1:0] word, input int k);
      return word[k*NIB_W +: NIB_W];
   endfunction

endpackage

// File: rtl/disp_pick.sv
// Combinational winner search over a request vector: fixed priority
// (lowest index wins, start ignored) or rotating search upward from start.
module disp_pick #(
   parameter int NREQ = 3,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   start,
   input  logic            rr,
   output logic [NREQ-1:0] win,
   output logic            valid
);

   // First requester found in search order becomes the one-hot winner.
   always_comb begin
      win   = '0;
      valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         int j;
         j = rr ? ((int'(start) + i) % NREQ) : i;
         if (!valid && req[j]) begin
            win[j] = 1'b1;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/disp_arbiter.sv
// Arbitrates the shared 6-digit display driver among NREQ sources using a
// registered req/grant handshake with a minimum-hold anti-flicker rule.
// Build option: define DISP_ARB_RR_EN for round-robin time-slicing instead
// of fixed priority with preemption.
module disp_arbiter
   import disp_pkg::*;
#(
   parameter int NREQ     = 3,
   parameter int MIN_HOLD = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DISP_W-1:0] disp_data,
   input  logic [NREQ*DP_W-1:0]   disp_dp,
   output logic [NREQ-1:0]        grant,
   output logic [NIB_W-1:0]       num0,
   output logic [NIB_W-1:0]       num1,
   output logic [NIB_W-1:0]       num2,
   output logic [NIB_W-1:0]       num3,
   output logic [NIB_W-1:0]       num4,
   output logic [NIB_W-1:0]       num5,
   output logic [DP_W-1:0]        dp_out,
   output logic                   busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HW = $clog2(MIN_HOLD + 1);

`ifdef DISP_ARB_RR_EN
   localparam logic RR_MODE = 1'b1;
`else
   localparam logic RR_MODE = 1'b0;
`endif

   state_t          state;
   logic [HW-1:0]   hold_cnt;
   logic [IW-1:0]   last_owner;   // current owner while in OWN
   logic [NREQ-1:0] higher_mask;
   logic [NREQ-1:0] pick_req;
   logic [IW-1:0]   pick_start;
   logic [NREQ-1:0] win;
   logic            win_valid;
   logic [IW-1:0]   win_idx;
   logic            hold_done;

   assign hold_done  = (hold_cnt == HW'(MIN_HOLD));
   assign pick_start = (int'(last_owner) == NREQ - 1) ? '0 : last_owner + 1'b1;

   // Requesters with strictly higher priority than the owner; masking also
   // keeps unknowns on lower-priority lines away from the winner search.
   always_comb begin
      higher_mask = '0;
      for (int j = 0; j < NREQ; j++) higher_mask[j] = (j < int'(last_owner));
   end

   // In OWN only challengers are searched: higher priority, or anyone else in rotation.
   always_comb begin
      pick_req = req;
      if (state == OWN) pick_req = RR_MODE ? (req & ~grant) : (req & higher_mask);
   end

   disp_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (pick_req),
      .start (pick_start),
      .rr    (RR_MODE),
      .win   (win),
      .valid (win_valid)
   );

   // One-hot winner to index.
   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) if (win[i]) win_idx = IW'(i);
   end

   // Grant FSM: handshake, minimum hold, preemption/rotation, registered outputs.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         grant      <= '0;
         busy       <= 1'b0;
         hold_cnt   <= '0;
         last_owner <= IW'(NREQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  state      <= OWN;
                  grant      <= win;
                  busy       <= 1'b1;
                  hold_cnt   <= '0;
                  last_owner <= win_idx;
               end
            end
            OWN: begin
               if (!req[last_owner]) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
               end else if (hold_done && win_valid) begin
                  grant      <= win;
                  hold_cnt   <= '0;
                  last_owner <= win_idx;
               end else if (!hold_done) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Display data path: follow the owner's slice one cycle behind grant, hold in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num0   <= '0;
         num1   <= '0;
         num2   <= '0;
         num3   <= '0;
         num4   <= '0;
         num5   <= '0;
         dp_out <= '0;
      end else if (busy) begin
         num0   <= digit(disp_data[DISP_W*int'(last_owner) +: DISP_W], 0);
         num1   <= digit(disp_data[DISP_W*int'(last_owner) +: DISP_W], 1);
         num2   <= digit(disp_data[DISP_W*int'(last_owner) +: DISP_W], 2);
         num3   <= digit(disp_data[DISP_W*int'(last_owner) +: DISP_W], 3);
         num4   <= digit(disp_data[DISP_W*int'(last_owner) +: DISP_W], 4);
         num5   <= digit(disp_data[DISP_W*int'(last_owner) +: DISP_W], 5);
         dp_out <= disp_dp[DP_W*int'(last_owner) +: DP_W];
      end
   end

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: directed scenarios plus randomized
// request/data traffic compared against a cycle-level behavioural model.
module tb_disp_arbiter;

   localparam int NREQ     = 3;
   localparam int MIN_HOLD = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic [71:0]     disp_data = '0;
   logic [17:0]     disp_dp = '0;
   logic [NREQ-1:0] grant;
   logic [3:0]      num0, num1, num2, num3, num4, num5;
   logic [5:0]      dp_out;
   logic            busy;

   int total = 0;
   int bad   = 0;

   // Model: owner index (-1 = idle), cycles owned so far, rotation pointer, shown data.
   int          m_owner;
   int          m_age;
   int          m_last;
   logic [23:0] m_nums;
   logic [5:0]  m_dp;

   disp_arbiter #(.NREQ(NREQ), .MIN_HOLD(MIN_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .disp_data(disp_data), .disp_dp(disp_dp),
      .grant(grant), .num0(num0), .num1(num1), .num2(num2), .num3(num3),
      .num4(num4), .num5(num5), .dp_out(dp_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_owner = -1;
      m_age   = 0;
      m_last  = NREQ - 1;
      m_nums  = '0;
      m_dp    = '0;
   endfunction

   // Who should take the display from idle, given the request pattern.
   function automatic int idle_winner(input logic [NREQ-1:0] r);
`ifdef DISP_ARB_RR_EN
      for (int i = 1; i <= NREQ; i++) if (r[(m_last + i) % NREQ]) return (m_last + i) % NREQ;
`else
      for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`endif
      return -1;
   endfunction

   // Who may take the display from the current owner once the hold time is served.
   function automatic int challenger(input logic [NREQ-1:0] r);
`ifdef DISP_ARB_RR_EN
      for (int i = 1; i < NREQ; i++) if (r[(m_owner + i) % NREQ]) return (m_owner + i) % NREQ;
`else
      for (int i = 0; i < m_owner; i++) if (r[i]) return i;
`endif
      return -1;
   endfunction

   // Apply one clock edge to the model using the inputs present at that edge.
   function automatic void model_edge();
      int w;
      if (m_owner >= 0) begin
         m_nums = disp_data[24*m_owner +: 24];
         m_dp   = disp_dp[6*m_owner +: 6];
      end
      if (m_owner < 0) begin
         w = idle_winner(req);
         if (w >= 0) begin
            m_owner = w; m_age = 1; m_last = w;
         end
      end else if (!req[m_owner]) begin
         m_owner = -1;
      end else begin
         w = (m_age >= MIN_HOLD + 1) ? challenger(req) : -1;
         if (w >= 0) begin
            m_owner = w; m_age = 1; m_last = w;
         end else begin
            m_age++;
         end
      end
   endfunction

   task automatic compare_all();
      logic [NREQ-1:0] exp_g;
      exp_g = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
      check("grant", 32'(grant), 32'(exp_g));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      check("nums", 32'({num5, num4, num3, num2, num1, num0}), 32'(m_nums));
      check("dp_out", 32'(dp_out), 32'(m_dp));
      check("onehot", 32'($countones(grant) <= 1), 32'(1));
   endtask

   task automatic step(input logic [NREQ-1:0] r);
      req = r;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic rand_data();
      for (int i = 0; i < NREQ; i++) begin
         disp_data[24*i +: 24] = 24'($urandom);
         disp_dp[6*i +: 6]     = 6'($urandom);
      end
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b0;
      req = '0;
      #2;
      model_reset();
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_nums", 32'({num5, num4, num3, num2, num1, num0}), 32'(0));
      check("rst_dp", 32'(dp_out), 32'(0));
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [NREQ-1:0] r;
      model_reset();
      #12;
      do_reset();

      // Single requester: grant next edge, data one edge later.
      disp_data[47:24] = 24'h123456;
      disp_dp[11:6]    = 6'b000100;
      step(3'b010);
      check("t1_grant", 32'(grant), 32'h2);
      step(3'b010);
      check("t1_num0", 32'(num0), 32'h6);
      check("t1_num5", 32'(num5), 32'h1);
      check("t1_dp", 32'(dp_out), 32'h04);
      check("t1_busy", 32'(busy), 32'h1);

      // Low-priority owner, higher-priority request arrives early.
      do_reset();
      rand_data();
      step(3'b100);
      step(3'b100);
      for (int i = 0; i < 8; i++) step(3'b101);
      step(3'b001);
      step(3'b001);

      // Owner drops while another is pending: one idle cycle.
      do_reset();
      step(3'b001);
      step(3'b011);
      step(3'b010);
      check("t3_idle", 32'(grant), 32'h0);
      step(3'b010);
      check("t3_regrant", 32'(grant), 32'h2);

      // Simultaneous owner drop and higher-priority request.
      step(3'b010);
      step(3'b001);
      check("t6_idle", 32'(busy), 32'h0);
      step(3'b001);
      check("t6_grant", 32'(grant), 32'h1);

      // All requesting: fixed owner stays, or rotation in time slices.
      do_reset();
      for (int i = 0; i < 20; i++) step(3'b111);

      // Reset mid-ownership with a known digit on display.
      disp_data = {3{24'h999999}};
      step(3'b111);
      step(3'b111);
      check("t5_pre", 32'(num0), 32'h9);
      do_reset();
      step(3'b100);
      check("t5_fresh", 32'(grant), 32'h4);

      // Randomized traffic: sticky request bits with occasional toggles.
      r = '0;
      for (int i = 0; i < 600; i++) begin
         rand_data();
         for (int b = 0; b < NREQ; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
         step(r);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
